// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-add multiplier for WIDTH-bit operands producing a
// 2*WIDTH-bit product. Signed mode multiplies magnitudes and fixes the sign
// at the end. A start/ready handshake launches an operation, done pulses for
// one cycle when the product is written, and abort cancels work in flight.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]      CNT_INIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIX   = 2'd2
    } state_t;

    state_t             state_reg;
    logic [WIDTH:0]     acc_reg;     // one spare bit absorbs the add carry
    logic [WIDTH-1:0]   q_reg;
    logic [WIDTH-1:0]   mcand_reg;   // |A|
    logic               neg_reg;     // result must be negated at the end
    logic [CW-1:0]      count_reg;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               neg_next;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] raw_prod;
    logic [2*WIDTH-1:0] fixed_prod;

    // Operand magnitudes and sign fixup; -2^(WIDTH-1) maps to 2^(WIDTH-1),
    // which still fits in WIDTH unsigned bits.
    always_comb begin
        mag_a      = (is_signed && multiplicand[WIDTH-1]) ? (~multiplicand + ONE_W) : multiplicand;
        mag_b      = (is_signed && multiplier[WIDTH-1])   ? (~multiplier + ONE_W)   : multiplier;
        neg_next   = is_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
        sum        = acc_reg + (q_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
        raw_prod   = {acc_reg[WIDTH-1:0], q_reg};
        fixed_prod = neg_reg ? (~raw_prod + ONE_2W) : raw_prod;
    end

    // Controller, datapath and counter; every output is a register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            product   <= '0;
            count_reg <= '0;
            acc_reg   <= '0;
            q_reg     <= '0;
            mcand_reg <= '0;
            neg_reg   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        acc_reg   <= '0;
                        q_reg     <= mag_b;
                        mcand_reg <= mag_a;
                        neg_reg   <= neg_next;
                        count_reg <= CNT_INIT;
                        state_reg <= SHIFT;
                        ready     <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state_reg <= IDLE;
                        ready     <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        // add-then-shift of {acc,Q}, zero filled from the top
                        acc_reg   <= {1'b0, sum[WIDTH:1]};
                        q_reg     <= {sum[0], q_reg[WIDTH-1:1]};
                        count_reg <= count_reg - CNT_ONE;
                        if (count_reg == '0) begin
                            state_reg <= FIX;
                        end
                    end
                end
                FIX: begin
                    // abort takes priority over completing the result
                    if (!abort) begin
                        product <= fixed_prod;
                        done    <= 1'b1;
                    end
                    state_reg <= IDLE;
                    ready     <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    ready     <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Testbench for seq_multiplier: WIDTH=8 directed scenarios plus random
// signed/unsigned runs on WIDTH=16 and WIDTH=2 instances, with expected
// products queued at start and compared when done appears.
module tb_seq_multiplier;

    logic clock;
    logic reset;

    logic        start8, abort8, sgn8, ready8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    logic        start16, abort16, sgn16, ready16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    logic        start2, abort2, sgn2, ready2, busy2, done2;
    logic [1:0]  a2, b2;
    logic [3:0]  p2;

    int checks;
    int failures;
    logic [63:0] exp_q[$];
    logic [15:0] last8;

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .abort(abort8),
        .is_signed(sgn8), .multiplicand(a8), .multiplier(b8),
        .ready(ready8), .busy(busy8), .done(done8), .product(p8)
    );

    seq_multiplier #(.WIDTH(16)) dut16 (
        .clock(clock), .reset(reset), .start(start16), .abort(abort16),
        .is_signed(sgn16), .multiplicand(a16), .multiplier(b16),
        .ready(ready16), .busy(busy16), .done(done16), .product(p16)
    );

    seq_multiplier #(.WIDTH(2)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .abort(abort2),
        .is_signed(sgn2), .multiplicand(a2), .multiplier(b2),
        .ready(ready2), .busy(busy2), .done(done2), .product(p2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference product: sign-extend when signed, multiply, keep 2*w bits.
    function automatic logic [63:0] ref_mul(input longint a, input longint b,
                                            input int w, input bit sgn);
        longint av, bv, mask;
        av = a;
        bv = b;
        if (sgn && a[w-1]) av = a - (longint'(1) << w);
        if (sgn && b[w-1]) bv = b - (longint'(1) << w);
        mask = (longint'(1) << (2*w)) - 1;
        return 64'(av * bv) & 64'(mask);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fail_line(input string name, input logic [63:0] got, input logic [63:0] expv);
        failures++;
        $display("FAIL %s got=%0h expected=%0h", name, got, expv);
    endtask

    // One WIDTH=8 operation: queue expected, launch, wait for done.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit sgn);
        int n;
        int ready_bad;
        logic [63:0] e;
        exp_q.push_back(ref_mul(longint'(a), longint'(b), 8, sgn));
        a8 = a; b8 = b; sgn8 = sgn; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
        checks++;
        if (busy8 !== 1'b1 || ready8 !== 1'b0) fail_line("w8_busy_after_start", {busy8, ready8}, 64'b10);
        n = 0;
        ready_bad = 0;
        do begin
            tick();
            n++;
            if (done8 !== 1'b1 && ready8 !== 1'b0) ready_bad++;
        end while (done8 !== 1'b1 && n < 40);
        checks++;
        if (n != 9) fail_line("w8_latency", 64'(n), 64'd9);
        checks++;
        if (ready_bad != 0) fail_line("w8_ready_low_while_busy", 64'(ready_bad), 64'd0);
        e = exp_q.pop_front();
        checks++;
        if (p8 !== e[15:0]) fail_line($sformatf("w8_product_%0h_x_%0h_s%0d", a, b, sgn), 64'(p8), e);
        checks++;
        if (ready8 !== 1'b1 || busy8 !== 1'b0) fail_line("w8_ready_at_done", {busy8, ready8}, 64'b01);
        last8 = e[15:0];
        $display("w8 %0h*%0h signed=%0d -> %0h (latency %0d)", a, b, sgn, p8, n);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input bit sgn);
        int n;
        logic [63:0] e;
        exp_q.push_back(ref_mul(longint'(a), longint'(b), 16, sgn));
        a16 = a; b16 = b; sgn16 = sgn; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        n = 0;
        do begin tick(); n++; end while (done16 !== 1'b1 && n < 60);
        checks++;
        if (n != 17) fail_line("w16_latency", 64'(n), 64'd17);
        e = exp_q.pop_front();
        checks++;
        if (p16 !== e[31:0]) fail_line($sformatf("w16_product_%0h_x_%0h_s%0d", a, b, sgn), 64'(p16), e);
        $display("w16 %0h*%0h signed=%0d -> %0h (latency %0d)", a, b, sgn, p16, n);
    endtask

    task automatic run2(input logic [1:0] a, input logic [1:0] b, input bit sgn);
        int n;
        logic [63:0] e;
        exp_q.push_back(ref_mul(longint'(a), longint'(b), 2, sgn));
        a2 = a; b2 = b; sgn2 = sgn; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n = 0;
        do begin tick(); n++; end while (done2 !== 1'b1 && n < 20);
        checks++;
        if (n != 3) fail_line("w2_latency", 64'(n), 64'd3);
        e = exp_q.pop_front();
        checks++;
        if (p2 !== e[3:0]) fail_line($sformatf("w2_product_%0h_x_%0h_s%0d", a, b, sgn), 64'(p2), e);
        $display("w2 %0h*%0h signed=%0d -> %0h (latency %0d)", a, b, sgn, p2, n);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (ready8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0) fail_line("reset_w8_flags", {ready8, busy8, done8}, 64'b100);
        checks++;
        if (p8 !== 16'h0) fail_line("reset_w8_product", 64'(p8), 64'h0);
        checks++;
        if (ready16 !== 1'b1 || done16 !== 1'b0 || p16 !== 32'h0) fail_line("reset_w16", {ready16, done16, p16}, 64'h200000000);
        checks++;
        if (ready2 !== 1'b1 || done2 !== 1'b0 || p2 !== 4'h0) fail_line("reset_w2", {ready2, done2, p2}, 64'h20);
        reset = 1'b0;
        tick();
        $display("reset: ready=%0d busy=%0d done=%0d product=%0h", ready8, busy8, done8, p8);
    endtask

    task automatic test_directed();
        run8(8'd13, 8'd11, 1'b0);
        checks++;
        if (p8 !== 16'h008F) fail_line("w8_13x11_const", 64'(p8), 64'h8F);
        tick();
        checks++;
        if (done8 !== 1'b0) fail_line("w8_done_one_cycle", 64'(done8), 64'd0);
        run8(8'd255, 8'd255, 1'b0);
        run8(8'hFD, 8'd5, 1'b1);     // -3 * 5
        run8(8'h80, 8'h80, 1'b1);    // -128 * -128
        run8(8'hF9, 8'd0, 1'b1);     // -7 * 0
        checks++;
        if (p8 !== 16'h0000) fail_line("w8_neg_times_zero", 64'(p8), 64'h0);
    endtask

    task automatic test_back_to_back();
        // consecutive calls start on the first ready cycle after done
        run8(8'd100, 8'd3, 1'b0);
        run8(8'h81, 8'h7F, 1'b1);
        run8(8'd13, 8'd11, 1'b0);
    endtask

    task automatic test_ignored_start();
        int n;
        int extra;
        logic [63:0] e;
        exp_q.push_back(ref_mul(longint'(13), longint'(11), 8, 1'b0));
        a8 = 8'd13; b8 = 8'd11; sgn8 = 1'b0; start8 = 1'b1;
        tick();                      // E0
        start8 = 1'b0;
        tick(); tick();              // E1, E2
        a8 = 8'd5; b8 = 8'd5; start8 = 1'b1;
        tick();                      // E3 samples the stray start
        start8 = 1'b0;
        n = 3;
        do begin tick(); n++; end while (done8 !== 1'b1 && n < 40);
        checks++;
        if (n != 9) fail_line("ignored_start_latency", 64'(n), 64'd9);
        e = exp_q.pop_front();
        checks++;
        if (p8 !== e[15:0]) fail_line("ignored_start_product", 64'(p8), e);
        last8 = e[15:0];
        extra = 0;
        repeat (14) begin
            tick();
            if (done8 === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) fail_line("ignored_start_second_done", 64'(extra), 64'd0);
        $display("ignored start: product=%0h extra_dones=%0d", p8, extra);
    endtask

    task automatic test_abort();
        int dones;
        a8 = 8'd200; b8 = 8'd3; sgn8 = 1'b0; start8 = 1'b1;
        tick();                      // E0
        start8 = 1'b0;
        repeat (4) tick();           // E1..E4
        abort8 = 1'b1;
        tick();                      // E5 samples abort
        abort8 = 1'b0;
        checks++;
        if (ready8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0) fail_line("abort_flags", {ready8, busy8, done8}, 64'b100);
        dones = 0;
        repeat (14) begin
            tick();
            if (done8 === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) fail_line("abort_done_seen", 64'(dones), 64'd0);
        checks++;
        if (p8 !== last8) fail_line("abort_product_held", 64'(p8), 64'(last8));
        // abort while idle does nothing
        abort8 = 1'b1;
        tick();
        abort8 = 1'b0;
        checks++;
        if (ready8 !== 1'b1 || p8 !== last8) fail_line("abort_idle", {ready8, p8}, {1'b1, last8});
        $display("abort: ready=%0d product=%0h dones=%0d", ready8, p8, dones);
    endtask

    task automatic test_reset_mid_shift();
        a8 = 8'd255; b8 = 8'd255; sgn8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        start8 = 1'b1;               // reset must win over start
        tick();
        reset = 1'b0;
        start8 = 1'b0;
        checks++;
        if (ready8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0) fail_line("midreset_flags", {ready8, busy8, done8}, 64'b100);
        checks++;
        if (p8 !== 16'h0) fail_line("midreset_product", 64'(p8), 64'h0);
        $display("reset mid-shift: ready=%0d product=%0h", ready8, p8);
        run8(8'd2, 8'd3, 1'b0);
        checks++;
        if (p8 !== 16'h0006) fail_line("midreset_2x3", 64'(p8), 64'h6);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            run16(16'($urandom), 16'($urandom), 1'($urandom));
        end
        run16(16'h8000, 16'h8000, 1'b1);
        run16(16'hFFFF, 16'hFFFF, 1'b0);
        for (int i = 0; i < 16; i++) begin
            run2(2'(i), 2'(i >> 2), 1'b1);
            run2(2'(i), 2'(i >> 2), 1'b0);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        last8 = '0;
        reset = 1'b1;
        start8 = 0; abort8 = 0; sgn8 = 0; a8 = 0; b8 = 0;
        start16 = 0; abort16 = 0; sgn16 = 0; a16 = 0; b16 = 0;
        start2 = 0; abort2 = 0; sgn2 = 0; a2 = 0; b2 = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_ignored_start();
        test_abort();
        test_reset_mid_shift();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
